// File: rtl/regfile_port_sched_pkg.sv
// rtl/regfile_port_sched_pkg.sv - shared widths, state encoding and constants for the regfile port scheduler
package regfile_sched_pkg;

  localparam int DATA_W_DEF       = 32;
  localparam int ADDR_W_DEF       = 5;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int REG_X0           = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD1  = 2'd1;
  localparam logic [1:0] ST_RD2  = 2'd2;
  localparam logic [1:0] ST_DBG  = 2'd3;

endpackage

// File: rtl/regfile_port_sched_if.sv
// rtl/regfile_port_sched_if.sv - CPU, debug and regfile signal bundle for regfile_port_sched
interface regfile_port_sched_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();

  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_rs1;
  logic [ADDR_W-1:0] cpu_rs2;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata1;
  logic [DATA_W-1:0] cpu_rdata2;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_waddr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;
  logic [ADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_do;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_di;
  logic              rf_we;

  modport slave (
    input  cpu_req, cpu_rs1, cpu_rs2, cpu_we, cpu_waddr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, rf_do,
    output cpu_ack, cpu_rdata1, cpu_rdata2, dbg_ack, dbg_rdata,
    output rf_raddr, rf_waddr, rf_di, rf_we
  );

  modport master (
    output cpu_req, cpu_rs1, cpu_rs2, cpu_we, cpu_waddr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, rf_do,
    input  cpu_ack, cpu_rdata1, cpu_rdata2, dbg_ack, dbg_rdata,
    input  rf_raddr, rf_waddr, rf_di, rf_we
  );

endinterface

// File: rtl/regfile_port_sched_arb_starve_ctr.sv
// rtl/regfile_port_sched_arb_starve_ctr.sv - saturating starvation counter guarding debug access
module arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset_i,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] cnt;

  assign sat = (cnt == CW'(STARVE_LIMIT));

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_port_sched.sv
// rtl/regfile_port_sched.sv - shares one regfile read port between CPU operand fetch and debug access
module regfile_port_sched
  import regfile_sched_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic                 clk,
  input logic                 reset_i,
  regfile_port_sched_if.slave bus
);

  localparam logic [ADDR_W-1:0] X0 = ADDR_W'(REG_X0);

  logic [1:0]        state;
  logic [ADDR_W-1:0] rs1_q;
  logic [ADDR_W-1:0] rs2_q;
  logic [ADDR_W-1:0] dbg_addr_q;
  logic              dbg_we_q;
  logic [DATA_W-1:0] dbg_wdata_q;
  logic              cpu_wr;
  logic              dbg_wr;
  logic              dbg_done;
  logic              starve_sat;
  logic [DATA_W-1:0] cap;

  // x0 reads as zero; a same-cycle write to the captured index wins over the stale array value
  function automatic logic [DATA_W-1:0] cap_val(
    input logic [ADDR_W-1:0] idx,
    input logic [DATA_W-1:0] rd,
    input logic              wr_en,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd
  );
    if (idx == X0)
      return '0;
    else if (wr_en && (wa == idx))
      return wd;
    else
      return rd;
  endfunction

  assign cpu_wr   = bus.cpu_we && (bus.cpu_waddr != X0);
  assign dbg_wr   = (state == ST_DBG) && dbg_we_q && (dbg_addr_q != X0) && !cpu_wr;
  assign dbg_done = (state == ST_DBG) && (!dbg_we_q || (dbg_addr_q == X0) || !cpu_wr);

  assign bus.rf_we    = !reset_i && (cpu_wr || dbg_wr);
  assign bus.rf_waddr = cpu_wr ? bus.cpu_waddr : dbg_addr_q;
  assign bus.rf_di    = cpu_wr ? bus.cpu_wdata : dbg_wdata_q;

  always_comb begin
    bus.rf_raddr = '0;
    case (state)
      ST_RD1:  bus.rf_raddr = rs1_q;
      ST_RD2:  bus.rf_raddr = rs2_q;
      ST_DBG:  bus.rf_raddr = dbg_addr_q;
      default: bus.rf_raddr = '0;
    endcase
  end

  assign cap = cap_val(bus.rf_raddr, bus.rf_do, bus.rf_we, bus.rf_waddr, bus.rf_di);

  arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk     (clk),
    .reset_i (reset_i),
    .inc     ((state == ST_RD2) && bus.dbg_req),
    .clr     (dbg_done),
    .sat     (starve_sat)
  );

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state          <= ST_IDLE;
      rs1_q          <= '0;
      rs2_q          <= '0;
      dbg_addr_q     <= '0;
      dbg_we_q       <= 1'b0;
      dbg_wdata_q    <= '0;
      bus.cpu_ack    <= 1'b0;
      bus.dbg_ack    <= 1'b0;
      bus.cpu_rdata1 <= '0;
      bus.cpu_rdata2 <= '0;
      bus.dbg_rdata  <= '0;
    end else begin
      bus.cpu_ack <= 1'b0;
      bus.dbg_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.dbg_req && (!bus.cpu_req || starve_sat)) begin
            state       <= ST_DBG;
            dbg_addr_q  <= bus.dbg_addr;
            dbg_we_q    <= bus.dbg_we;
            dbg_wdata_q <= bus.dbg_wdata;
          end else if (bus.cpu_req) begin
            state <= ST_RD1;
            rs1_q <= bus.cpu_rs1;
            rs2_q <= bus.cpu_rs2;
          end
        end
        ST_RD1: begin
          bus.cpu_rdata1 <= cap;
          state          <= ST_RD2;
        end
        ST_RD2: begin
          bus.cpu_rdata2 <= cap;
          bus.cpu_ack    <= 1'b1;
          state          <= ST_IDLE;
        end
        ST_DBG: begin
          // a debug write that loses to a CPU write simply stays here and retries
          if (dbg_done) begin
            bus.dbg_ack <= 1'b1;
            if (!dbg_we_q)
              bus.dbg_rdata <= cap;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_port_sched.sv
// tb/tb_regfile_port_sched.sv - self-checking bench for regfile_port_sched with a behavioural regfile
module tb_regfile_port_sched;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
  } cpu_exp_t;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] rf_mem [32];
  logic [31:0] mdl    [32];
  cpu_exp_t    cpu_q[$];
  logic [31:0] dbg_q[$];
  int          checks = 0;
  int          passes = 0;

  regfile_port_sched_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_port_sched #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4)) dut (
    .clk     (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.rf_we) rf_mem[bus.rf_waddr] <= bus.rf_di;
  assign bus.rf_do = rf_mem[bus.rf_raddr];

  task automatic cpu_read(input logic [4:0] a, input logic [4:0] b, output int lat);
    cpu_exp_t e;
    e.d1 = mdl[a];
    e.d2 = mdl[b];
    cpu_q.push_back(e);
    @(negedge clk);
    bus.cpu_req = 1'b1;
    bus.cpu_rs1 = a;
    bus.cpu_rs2 = b;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.cpu_ack) break;
    end
    bus.cpu_req = 1'b0;
  endtask

  task automatic cpu_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cpu_we    = 1'b1;
    bus.cpu_waddr = a;
    bus.cpu_wdata = d;
    @(negedge clk);
    bus.cpu_we = 1'b0;
    if (a != 5'd0) mdl[a] = d;
  endtask

  task automatic dbg_access(input logic we, input logic [4:0] a, input logic [31:0] d,
                            output int lat, output bit saw_rf_we);
    @(negedge clk);
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = we;
    bus.dbg_addr  = a;
    bus.dbg_wdata = d;
    lat = 0;
    saw_rf_we = 1'b0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.rf_we) saw_rf_we = 1'b1;
      if (bus.dbg_ack) break;
    end
    bus.dbg_req = 1'b0;
    if (we && a != 5'd0) mdl[a] = d;
  endtask

  task automatic test_reset();
    bus.cpu_we    = 1'b1;
    bus.cpu_waddr = 5'd3;
    bus.cpu_wdata = 32'h3333_3333;
    repeat (2) @(negedge clk);
    checks++; if (bus.rf_we !== 1'b0) $display("FAIL reset_rf_we: got %b expected 0", bus.rf_we); else passes++;
    checks++; if (bus.cpu_ack !== 1'b0 || bus.dbg_ack !== 1'b0)
      $display("FAIL reset_acks: got %b%b expected 00", bus.cpu_ack, bus.dbg_ack); else passes++;
    checks++; if ({bus.cpu_rdata1, bus.cpu_rdata2, bus.dbg_rdata} !== 96'd0)
      $display("FAIL reset_rdata: got %h %h %h expected 0", bus.cpu_rdata1, bus.cpu_rdata2, bus.dbg_rdata); else passes++;
    checks++; if (bus.rf_raddr !== 5'd0) $display("FAIL reset_raddr: got %0d expected 0", bus.rf_raddr); else passes++;
    bus.cpu_we = 1'b0;
    reset_i = 1'b0;
  endtask

  task automatic test_cpu_read();
    int lat;
    cpu_exp_t e;
    cpu_write(5'd5, 32'h1111_1111);
    cpu_write(5'd6, 32'h2222_2222);
    cpu_write(5'd3, 32'h0000_0333);
    cpu_write(5'd7, 32'h0000_0777);
    cpu_read(5'd5, 5'd6, lat);
    e = cpu_q.pop_front();
    checks++; if (lat !== 3) $display("FAIL read_latency: got %0d expected 3", lat); else passes++;
    checks++; if (bus.cpu_rdata1 !== e.d1) $display("FAIL read_rdata1: got %h expected %h", bus.cpu_rdata1, e.d1); else passes++;
    checks++; if (bus.cpu_rdata2 !== e.d2) $display("FAIL read_rdata2: got %h expected %h", bus.cpu_rdata2, e.d2); else passes++;
    @(negedge clk);
    checks++; if (bus.cpu_ack !== 1'b0) $display("FAIL ack_pulse: got %b expected 0", bus.cpu_ack); else passes++;
  endtask

  task automatic test_x0();
    int lat;
    bit saw;
    cpu_exp_t e;
    dbg_access(1'b1, 5'd0, 32'hDEAD_BEEF, lat, saw);
    checks++; if (lat !== 2) $display("FAIL x0_dbg_ack: got latency %0d expected 2", lat); else passes++;
    checks++; if (saw !== 1'b0) $display("FAIL x0_rf_we: got %b expected 0", saw); else passes++;
    cpu_read(5'd0, 5'd0, lat);
    e = cpu_q.pop_front();
    checks++; if (lat !== 3 || bus.cpu_rdata1 !== e.d1 || bus.cpu_rdata2 !== e.d2)
      $display("FAIL x0_read: got lat %0d %h %h expected 3 %h %h", lat, bus.cpu_rdata1, bus.cpu_rdata2, e.d1, e.d2); else passes++;
    dbg_q.push_back(mdl[0]);
    dbg_access(1'b0, 5'd0, 32'h0, lat, saw);
    checks++; if (bus.dbg_rdata !== dbg_q[0]) $display("FAIL x0_dbg_read: got %h expected %h", bus.dbg_rdata, dbg_q[0]); else passes++;
    void'(dbg_q.pop_front());
  endtask

  task automatic test_bypass();
    int lat;
    cpu_exp_t e;
    e.d1 = mdl[3];
    e.d2 = 32'hCAFE_F00D;
    cpu_q.push_back(e);
    @(negedge clk);
    bus.cpu_req = 1'b1;
    bus.cpu_rs1 = 5'd3;
    bus.cpu_rs2 = 5'd7;
    @(negedge clk);
    @(negedge clk);
    bus.cpu_we    = 1'b1;
    bus.cpu_waddr = 5'd7;
    bus.cpu_wdata = 32'hCAFE_F00D;
    #1;
    checks++; if (bus.rf_raddr !== 5'd7) $display("FAIL bypass_raddr: got %0d expected 7", bus.rf_raddr); else passes++;
    @(negedge clk);
    bus.cpu_we  = 1'b0;
    bus.cpu_req = 1'b0;
    mdl[7] = 32'hCAFE_F00D;
    e = cpu_q.pop_front();
    checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata1 !== e.d1 || bus.cpu_rdata2 !== e.d2)
      $display("FAIL bypass_rd2: got ack %b %h %h expected 1 %h %h", bus.cpu_ack, bus.cpu_rdata1, bus.cpu_rdata2, e.d1, e.d2); else passes++;
    cpu_read(5'd7, 5'd0, lat);
    e = cpu_q.pop_front();
    checks++; if (bus.cpu_rdata1 !== e.d1 || bus.cpu_rdata2 !== e.d2)
      $display("FAIL bypass_later: got %h %h expected %h %h", bus.cpu_rdata1, bus.cpu_rdata2, e.d1, e.d2); else passes++;
  endtask

  task automatic test_starve();
    int acks = 0;
    int last_ack = 0;
    int cyc = 0;
    int dbg_cyc = -1;
    bit data_ok = 1'b1;
    logic [31:0] exp_d;
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_rs1  = 5'd5;
    bus.cpu_rs2  = 5'd6;
    bus.dbg_req  = 1'b1;
    bus.dbg_we   = 1'b0;
    bus.dbg_addr = 5'd5;
    dbg_q.push_back(mdl[5]);
    while (cyc < 200 && dbg_cyc < 0) begin
      @(negedge clk);
      cyc++;
      if (bus.cpu_ack) begin
        acks++;
        last_ack = cyc;
        if (bus.cpu_rdata1 !== mdl[5] || bus.cpu_rdata2 !== mdl[6]) data_ok = 1'b0;
      end
      if (bus.dbg_ack) begin
        dbg_cyc = cyc;
        bus.dbg_req = 1'b0;
        bus.cpu_req = 1'b0;
      end
    end
    bus.dbg_req = 1'b0;
    bus.cpu_req = 1'b0;
    exp_d = dbg_q.pop_front();
    checks++; if (acks !== 4) $display("FAIL starve_acks: got %0d expected 4", acks); else passes++;
    checks++; if (dbg_cyc - last_ack !== 2) $display("FAIL starve_grant_gap: got %0d expected 2", dbg_cyc - last_ack); else passes++;
    checks++; if (bus.dbg_rdata !== exp_d) $display("FAIL starve_dbg_rdata: got %h expected %h", bus.dbg_rdata, exp_d); else passes++;
    checks++; if (data_ok !== 1'b1) $display("FAIL starve_cpu_data: got %b expected 1", data_ok); else passes++;
    @(negedge clk);
  endtask

  task automatic test_collision();
    int lat;
    cpu_exp_t e;
    @(negedge clk);
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = 1'b1;
    bus.dbg_addr  = 5'd9;
    bus.dbg_wdata = 32'h5A5A_5A5A;
    @(negedge clk);
    bus.cpu_we    = 1'b1;
    bus.cpu_waddr = 5'd9;
    bus.cpu_wdata = 32'h0000_0001;
    #1;
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_di !== 32'h1 || bus.dbg_ack !== 1'b0)
      $display("FAIL coll_cpu_first: got we %b di %h ack %b expected 1 00000001 0", bus.rf_we, bus.rf_di, bus.dbg_ack); else passes++;
    @(negedge clk);
    bus.cpu_we = 1'b0;
    #1;
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_di !== 32'h5A5A_5A5A || bus.rf_waddr !== 5'd9 || bus.dbg_ack !== 1'b0)
      $display("FAIL coll_dbg_retry: got we %b di %h wa %0d ack %b expected 1 5a5a5a5a 9 0", bus.rf_we, bus.rf_di, bus.rf_waddr, bus.dbg_ack); else passes++;
    @(negedge clk);
    checks++; if (bus.dbg_ack !== 1'b1) $display("FAIL coll_dbg_ack: got %b expected 1", bus.dbg_ack); else passes++;
    bus.dbg_req = 1'b0;
    mdl[9] = 32'h5A5A_5A5A;
    cpu_read(5'd9, 5'd0, lat);
    e = cpu_q.pop_front();
    checks++; if (bus.cpu_rdata1 !== e.d1 || bus.cpu_rdata2 !== e.d2)
      $display("FAIL coll_readback: got %h %h expected %h %h", bus.cpu_rdata1, bus.cpu_rdata2, e.d1, e.d2); else passes++;
  endtask

  task automatic test_async_reset();
    int lat;
    cpu_exp_t e;
    cpu_read(5'd5, 5'd6, lat);
    void'(cpu_q.pop_front());
    @(negedge clk);
    bus.cpu_req = 1'b1;
    bus.cpu_rs1 = 5'd6;
    bus.cpu_rs2 = 5'd5;
    @(negedge clk);
    @(negedge clk);
    #2 reset_i = 1'b1;
    #1;
    checks++; if ({bus.cpu_rdata1, bus.cpu_rdata2, bus.dbg_rdata} !== 96'd0)
      $display("FAIL areset_rdata: got %h %h %h expected 0", bus.cpu_rdata1, bus.cpu_rdata2, bus.dbg_rdata); else passes++;
    checks++; if (bus.rf_raddr !== 5'd0) $display("FAIL areset_raddr: got %0d expected 0", bus.rf_raddr); else passes++;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.cpu_ack !== 1'b0) $display("FAIL areset_no_ack: got %b expected 0", bus.cpu_ack); else passes++;
    reset_i = 1'b0;
    cpu_read(5'd6, 5'd5, lat);
    e = cpu_q.pop_front();
    checks++; if (lat !== 3 || bus.cpu_rdata1 !== e.d1 || bus.cpu_rdata2 !== e.d2)
      $display("FAIL areset_recover: got lat %0d %h %h expected 3 %h %h", lat, bus.cpu_rdata1, bus.cpu_rdata2, e.d1, e.d2); else passes++;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = 32'h0;
      mdl[i]    = 32'h0;
    end
    rf_mem[0]     = 32'hBAD0_BAD0;
    bus.cpu_req   = 1'b0;
    bus.cpu_rs1   = '0;
    bus.cpu_rs2   = '0;
    bus.cpu_we    = 1'b0;
    bus.cpu_waddr = '0;
    bus.cpu_wdata = '0;
    bus.dbg_req   = 1'b0;
    bus.dbg_we    = 1'b0;
    bus.dbg_addr  = '0;
    bus.dbg_wdata = '0;
    test_reset();
    test_cpu_read();
    test_x0();
    test_bypass();
    test_starve();
    test_collision();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
